// File: rtl/sseg_pkg.sv
// Shared types and constants for the ROM-backed seven-segment scanner.
// Also holds the leading-zero test used when SSEG_LEADING_ZERO_BLANK_EN is defined.
package sseg_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Active-low enable for a single digit.
    function automatic logic [3:0] digit_an(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

    // A digit is a leading zero when it and every higher nibble are zero; digit 0 never is.
    function automatic logic lz_blank(input logic [15:0] hex, input logic [1:0] digit);
        logic blank;
        case (digit)
            2'd3:    blank = (hex[15:12] == 4'h0);
            2'd2:    blank = (hex[15:8]  == 8'h00);
            2'd1:    blank = (hex[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/sseg_rom_scan.sv
// Four-digit multiplexed seven-segment scanner that fetches patterns from an external
// 1-cycle ROM. Optional leading-zero blanking via macro SSEG_LEADING_ZERO_BLANK_EN.
module sseg_rom_scan
    import sseg_pkg::*;
#(
    parameter int N   = 18,
    parameter int GAP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    output logic [3:0]  rom_addr,
    input  logic [6:0]  rom_data,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    localparam int              GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [N-1:0]     DWELL_LAST = {N{1'b1}};

    state_e           state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [N-1:0]     dwell_q, dwell_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      hex_q, hex_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       addr_q, addr_d;
    logic             dpl_q, dpl_d;
    logic             blank_q, blank_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       sseg_q, sseg_d;
    logic [3:0]       nibble_s;

    assign nibble_s = hex_q[{digit_q, 2'b00} +: 4];

    // The address is live in FETCH and frozen in WAIT so a shadow write cannot disturb the read.
    assign rom_addr = (state_q == sseg_pkg::FETCH) ? nibble_s : addr_q;
    assign an       = an_q;
    assign sseg     = sseg_q;

    // Next-state logic for the scan FSM, shadow registers and output registers.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        dwell_d = dwell_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        dpl_d   = dpl_q;
        blank_d = blank_q;
        an_d    = an_q;
        sseg_d  = sseg_q;
        if (wr) begin
            hex_d = hex_in;
            dp_d  = dp_in;
        end else begin
            hex_d = hex_q;
            dp_d  = dp_q;
        end

        case (state_q)
            sseg_pkg::FETCH: begin
                state_d = sseg_pkg::WAIT;
                addr_d  = nibble_s;
                dpl_d   = dp_q[digit_q];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
                blank_d = lz_blank(hex_q, digit_q);
`else
                blank_d = 1'b0;
`endif
            end
            sseg_pkg::WAIT: begin
                state_d = sseg_pkg::DRIVE;
                sseg_d  = {~dpl_q, (blank_q ? SSEG_BLANK[6:0] : rom_data)};
                an_d    = digit_an(digit_q);
                dwell_d = '0;
            end
            sseg_pkg::DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = sseg_pkg::GAP;
                    an_d    = 4'b1111;
                    gap_d   = '0;
                end else begin
                    dwell_d = dwell_q + {{(N-1){1'b0}}, 1'b1};
                end
            end
            sseg_pkg::GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = sseg_pkg::FETCH;
                    digit_d = digit_q + 2'd1;
                end else begin
                    gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = sseg_pkg::FETCH;
                an_d    = 4'b1111;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the blanked display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= sseg_pkg::FETCH;
            digit_q <= 2'd0;
            dwell_q <= '0;
            gap_q   <= '0;
            hex_q   <= 16'h0000;
            dp_q    <= 4'h0;
            addr_q  <= 4'h0;
            dpl_q   <= 1'b0;
            blank_q <= 1'b0;
            an_q    <= 4'b1111;
            sseg_q  <= SSEG_BLANK;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            dwell_q <= dwell_d;
            gap_q   <= gap_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            addr_q  <= addr_d;
            dpl_q   <= dpl_d;
            blank_q <= blank_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
        end
    end

endmodule

// File: tb/tb_sseg_rom_scan.sv
// Directed bench for sseg_rom_scan with N=2, GAP=2 and a behavioural 1-cycle hex ROM.
module tb_sseg_rom_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  rom_addr;
    logic [6:0]  rom_data;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int checks = 0;
    int errors = 0;

    logic [6:0] rom_tab [16];

    always #5 clk = ~clk;

    sseg_rom_scan #(.N(2), .GAP(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .hex_in   (hex_in),
        .dp_in    (dp_in),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .an       (an),
        .sseg     (sseg)
    );

    always_ff @(posedge clk) rom_data <= rom_tab[rom_addr];

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [7:0]  exp [4];
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        @(negedge clk);
        while (an !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (an !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_an: got %b expected %b (timeout)", an, target);
        end
    endtask

    task automatic reset_seq();
        reset = 1'b1;
        #1;
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_sseg", sseg, 8'hFF);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 2) begin
                chk("post_rst_an", {4'h0, an}, 8'h0F);
                chk("post_rst_sseg", sseg, 8'hFF);
            end else if (k < 6) begin
                chk("first_digit_an", {4'h0, an}, 8'h0E);
                chk("first_digit_sseg", sseg, 8'hC0);
            end else begin
                chk("first_gap_an", {4'h0, an}, 8'h0F);
            end
        end
    endtask

    task automatic do_wr(input logic [15:0] h, input logic [3:0] d);
        @(negedge clk);
        wr = 1'b1;
        hex_in = h;
        dp_in = d;
        @(posedge clk);
        #1 wr = 1'b0;
    endtask

    initial begin
        rom_tab[0]  = 7'h40; rom_tab[1]  = 7'h79; rom_tab[2]  = 7'h24; rom_tab[3]  = 7'h30;
        rom_tab[4]  = 7'h19; rom_tab[5]  = 7'h12; rom_tab[6]  = 7'h02; rom_tab[7]  = 7'h78;
        rom_tab[8]  = 7'h00; rom_tab[9]  = 7'h10; rom_tab[10] = 7'h08; rom_tab[11] = 7'h03;
        rom_tab[12] = 7'h46; rom_tab[13] = 7'h21; rom_tab[14] = 7'h06; rom_tab[15] = 7'h0E;

        vecs[0] = '{16'h12AF, 4'b0100, '{8'h8E, 8'h88, 8'h24, 8'hF9}};
        vecs[1] = '{16'h8421, 4'b1001, '{8'h79, 8'hA4, 8'h99, 8'h00}};
        vecs[2] = '{16'hCDE3, 4'b1111, '{8'h30, 8'h06, 8'h21, 8'h46}};
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        vecs[3] = '{16'h0000, 4'b0000, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
        vecs[4] = '{16'h0005, 4'b0000, '{8'h92, 8'hFF, 8'hFF, 8'hFF}};
        vecs[5] = '{16'h0105, 4'b1000, '{8'h92, 8'hC0, 8'hF9, 8'h7F}};
`else
        vecs[3] = '{16'h0000, 4'b0000, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[4] = '{16'h0005, 4'b0000, '{8'h92, 8'hC0, 8'hC0, 8'hC0}};
        vecs[5] = '{16'h0105, 4'b1000, '{8'h92, 8'hC0, 8'hF9, 8'h40}};
`endif

        wr = 1'b0;
        hex_in = 16'h0000;
        dp_in = 4'h0;
        reset_seq();

        // Full 32-cycle scan per vector, aligned to the first DRIVE cycle of digit 0.
        for (int v = 0; v < 6; v++) begin
            do_wr(vecs[v].hex, vecs[v].dp);
            wait_an(4'b0111);
            wait_an(4'b1110);
            for (int p = 0; p < 33; p++) begin
                int d;
                logic [3:0] exp_an;
                if (p > 0) @(negedge clk);
                d = (p / 8) % 4;
                exp_an = ((p % 8) < 4) ? ~(4'b0001 << d) : 4'b1111;
                chk("scan_an", {4'h0, an}, {4'h0, exp_an});
                chk("an_onehot", {4'h0, 4'($countones(~an))} <= 8'd1 ? 8'd1 : 8'd0, 8'd1);
                if (p < 32) chk("scan_sseg", sseg, vecs[v].exp[d]);
            end
        end

        // Shadow write in the middle of digit 1's DRIVE must not disturb it.
        do_wr(16'h12AF, 4'b0100);
        wait_an(4'b0111);
        wait_an(4'b1110);
        wait_an(4'b1101);
        chk("mid_pre", sseg, 8'h88);
        wr = 1'b1;
        hex_in = 16'h3456;
        dp_in = 4'b0000;
        @(posedge clk);
        #1 wr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_hold", sseg, 8'h88);
        end
        wait_an(4'b1011);
        chk("mid_d2_new", sseg, 8'h99);
        wait_an(4'b0111);
        chk("mid_d3_new", sseg, 8'hB0);
        wait_an(4'b1110);
        chk("mid_d0_new", sseg, 8'h82);
        wait_an(4'b1101);
        chk("mid_d1_new", sseg, 8'h92);

        // Reset in the middle of digit 2's DRIVE aborts at once and restarts at digit 0.
        wait_an(4'b1011);
        @(negedge clk);
        reset_seq();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
